rc4_core_scheduler: RTL and testbench
=====================================

Name: rc4_core_scheduler

Overview:
- Dispatches 24-bit secret-key candidates to NUM_CORES RC4 decryption sub-cores and collects their verdicts.
- Each sub-core runs one candidate per reset, so the scheduler holds it in reset between jobs, then starts it and waits for finish.
- Stops at the first key that decrypts to valid text, or when the key space is exhausted.
- Sits between the top-level key-search control (switches/LEDs/HEX) and the sub-core array.

Parameters:
- NUM_CORES, 4, number of sub-cores driven (1..8).
- KEY_MAX, 24'h3FFFFF, last candidate key tried; search runs 0..KEY_MAX inclusive.
- RESET_CYCLES, 2, minimum consecutive cycles core_reset is held high before a core is restarted (>=1).
- RUN_TIMEOUT, 20000, cycles a core may stay in RUN before it is aborted as failed.

Ports:
- CLOCK_50 input 1: system clock.
- reset input 1: synchronous, active-high reset.
- go input 1: start a search; one-cycle pulse or level, sampled only in G_IDLE/G_DONE.
- core_reset output NUM_CORES: per-core reset, high = core parked.
- core_start output NUM_CORES: per-core start request.
- core_key output 24*NUM_CORES: per-core secret key; core n uses bits [24n+23:24n].
- core_start_done input NUM_CORES: core acknowledged start.
- core_finish input NUM_CORES: core reached its terminal state.
- core_keyfound input NUM_CORES: verdict; valid only while the matching finish is high.
- busy output 1: search in progress.
- done output 1: search ended.
- found output 1: done with a valid key.
- found_key output 24: winning key.
- found_core output 3: index of the winning core.
- timeout_err output 1: sticky; set when any core hit RUN_TIMEOUT during the current search.

Behaviour:
- Reset values:
  - Global FSM = G_IDLE; all per-core FSMs = C_IDLE.
  - core_reset all 1s; core_start 0; core_key 0.
  - busy, done, found, timeout_err = 0; found_key = 0; found_core = 0.
  - next_key = 0; all hold counters = 0.
- Global FSM:
  - G_IDLE/G_DONE: when go=1, clear done, found, found_key, found_core, timeout_err; set next_key=0; go to G_RUN. busy=1 from the next cycle.
  - G_RUN: dispatch and collect as below.
    - Any verdict with keyfound=1 -> G_DONE with found=1.
    - next_key > KEY_MAX and all cores in C_IDLE -> G_DONE with found=0.
  - G_DONE: busy=0, done=1. Results hold until the next go.
  - go while in G_RUN is ignored.
- Per-core FSM:
  - C_IDLE: core_reset=1, core_start=0. The hold counter counts up to RESET_CYCLES and saturates; it clears on entry to C_IDLE.
  - C_START: core_reset=0, core_start=1. Stay until core_start_done=1, then go to C_RUN.
  - C_RUN: core_reset=0, core_start=0. The run counter increments each cycle.
    - On core_finish=1, present the verdict to the collector and go to C_IDLE.
    - When the run counter reaches RUN_TIMEOUT, set timeout_err, treat as failed, and go to C_IDLE.
- Dispatch, G_RUN only:
  - At most one core per cycle.
  - Winner = lowest-index core in C_IDLE with a saturated hold counter, and only while next_key <= KEY_MAX.
  - On the dispatch edge: core_key[n] <= next_key; next_key <= next_key+1 (25-bit compare, no wrap); core n -> C_START.
  - Latency from dispatch edge: core_reset low and core_start high on the following cycle.
- Collection:
  - When several cores finish in the same cycle, the lowest index with keyfound=1 wins. found_key = that core's core_key; found_core = its index.
  - On a find:
    - Latch found_key and found_core.
    - Force every core to C_IDLE in the same cycle, which aborts in-flight jobs (core_reset=1 next cycle).
    - Suppress dispatch that cycle.
  - keyfound with finish=0 is ignored.
- Boundary conditions:
  - KEY_MAX < NUM_CORES: unused cores stay in C_IDLE.
  - Key KEY_MAX finishing with failure ends the search once every other core is idle.
  - Reset mid-search returns all outputs to reset values on the next edge; cores are parked by core_reset=1.
  - start_done never asserts: the core stays in C_START. No timeout applies in C_START.

Test Plan:
- Core model verdicts succeed only for key 0x000005; NUM_CORES=4, KEY_MAX=0x3FFFFF; pulse go -> found=1, found_key=0x000005, all core_reset high the cycle after the finish, done=1, busy=0.
- KEY_MAX=7, no key succeeds -> exactly 8 dispatches with keys 0..7, each key once; done=1, found=0 after the last core returns to C_IDLE.
- Cores 1 and 3 finish in the same cycle, both keyfound=1 -> found_core=1, found_key=core_key[1].
- Reset at startup; go at cycle 0 -> core 0 gets key 0 once its hold counter saturates (RESET_CYCLES=2); cores 1,2,3 follow on consecutive cycles with keys 1,2,3.
- One model core never asserts finish, RUN_TIMEOUT=50 -> timeout_err=1 after 50 cycles in C_RUN; the core returns to C_IDLE; the search continues and completes.
- Assert reset mid-search, then pulse go -> outputs cleared; a second go restarts from key 0 and returns the same result as the first run.

Source files
------------

// File: rtl/rc4_core_scheduler_if.sv
// Scheduler <-> RC4 sub-core array bus.
// master (scheduler): drives core_reset, core_start, core_key.
// slave  (core array): drives core_start_done, core_finish, core_keyfound.
// Core n owns bit n of each per-core vector and bits [24n+23:24n] of core_key.
interface rc4_core_scheduler_if #(
    parameter int unsigned NUM_CORES = 4
) ();
    logic [NUM_CORES-1:0]    core_reset;
    logic [NUM_CORES-1:0]    core_start;
    logic [24*NUM_CORES-1:0] core_key;
    logic [NUM_CORES-1:0]    core_start_done;
    logic [NUM_CORES-1:0]    core_finish;
    logic [NUM_CORES-1:0]    core_keyfound;

    modport master (
        output core_reset,
        output core_start,
        output core_key,
        input  core_start_done,
        input  core_finish,
        input  core_keyfound
    );

    modport slave (
        input  core_reset,
        input  core_start,
        input  core_key,
        output core_start_done,
        output core_finish,
        output core_keyfound
    );
endinterface

// File: rtl/rc4_core_scheduler.sv
// Key-search scheduler: hands 24-bit candidate keys 0..KEY_MAX to NUM_CORES RC4 sub-cores,
// parking each core in reset between jobs, and stops at the first key reported valid or
// when the key space is exhausted.
// Ports:
//   CLOCK_50, reset  - clock and synchronous active-high reset
//   go               - start a search (sampled only while idle or done)
//   cores            - sub-core bus (reset/start/key out, start_done/finish/keyfound in)
//   busy, done       - search in progress / search ended
//   found            - search ended with a valid key
//   found_key/_core  - winning key and index of the core that tested it
//   timeout_err      - sticky per search: some core overran RUN_TIMEOUT cycles in RUN
module rc4_core_scheduler #(
    parameter int unsigned NUM_CORES    = 4,
    parameter logic [23:0] KEY_MAX      = 24'h3FFFFF,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned RUN_TIMEOUT  = 20000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 go,
    rc4_core_scheduler_if.master cores,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [23:0]          found_key,
    output logic [2:0]           found_core,
    output logic                 timeout_err
);
    localparam int unsigned      HoldW    = $clog2(RESET_CYCLES + 1);
    localparam int unsigned      RunW     = $clog2(RUN_TIMEOUT + 1);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(RESET_CYCLES);
    localparam logic [RunW-1:0]  RunLast  = RunW'(RUN_TIMEOUT - 1);
    // 25-bit limit so next_key can step past 24'hFFFFFF without wrapping
    localparam logic [24:0]      KeyLimit = {1'b0, KEY_MAX};

    typedef enum logic [1:0] {GIdle, GRun, GDone} gstate_e;
    typedef enum logic [1:0] {CIdle, CStart, CRun} cstate_e;

    gstate_e              gst_q;
    cstate_e              cst_q  [NUM_CORES];
    logic [HoldW-1:0]     hold_q [NUM_CORES];
    logic [RunW-1:0]      run_q  [NUM_CORES];
    logic [23:0]          key_q  [NUM_CORES];
    logic [NUM_CORES-1:0] rst_q;
    logic [NUM_CORES-1:0] start_q;
    logic [24:0]          next_key_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 found_q;
    logic                 terr_q;
    logic [23:0]          found_key_q;
    logic [2:0]           found_core_q;

    logic                 keys_left;
    logic                 all_idle;
    logic                 find_v;
    logic [23:0]          find_key;
    logic [2:0]           find_idx;
    logic                 picked;
    logic [NUM_CORES-1:0] disp_oh;
    logic [24*NUM_CORES-1:0] key_flat;

    // Collector and dispatcher: both pick the lowest index. A find suppresses dispatch
    // because every core is being forced back to idle on the same edge.
    always_comb begin
        keys_left = (next_key_q <= KeyLimit);
        all_idle  = 1'b1;
        find_v    = 1'b0;
        find_key  = '0;
        find_idx  = '0;
        picked    = 1'b0;
        disp_oh   = '0;
        for (int n = 0; n < int'(NUM_CORES); n++) begin
            if (cst_q[n] != CIdle) begin
                all_idle = 1'b0;
            end
            if (!find_v && cst_q[n] == CRun && cores.core_finish[n] &&
                cores.core_keyfound[n]) begin
                find_v   = 1'b1;
                find_key = key_q[n];
                find_idx = 3'(n);
            end
        end
        if (gst_q == GRun && keys_left && !find_v) begin
            for (int n = 0; n < int'(NUM_CORES); n++) begin
                if (!picked && cst_q[n] == CIdle && hold_q[n] == HoldSat) begin
                    picked     = 1'b1;
                    disp_oh[n] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        key_flat = '0;
        for (int n = 0; n < int'(NUM_CORES); n++) begin
            key_flat[24*n +: 24] = key_q[n];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            gst_q        <= GIdle;
            next_key_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            terr_q       <= 1'b0;
            found_key_q  <= '0;
            found_core_q <= '0;
            rst_q        <= '1;
            start_q      <= '0;
            for (int n = 0; n < int'(NUM_CORES); n++) begin
                cst_q[n]  <= CIdle;
                hold_q[n] <= '0;
                run_q[n]  <= '0;
                key_q[n]  <= '0;
            end
        end else begin
            // Per-core job FSMs
            for (int n = 0; n < int'(NUM_CORES); n++) begin
                unique case (cst_q[n])
                    CIdle: begin
                        if (disp_oh[n]) begin
                            cst_q[n]   <= CStart;
                            key_q[n]   <= next_key_q[23:0];
                            rst_q[n]   <= 1'b0;
                            start_q[n] <= 1'b1;
                        end else if (hold_q[n] != HoldSat) begin
                            hold_q[n] <= hold_q[n] + 1'b1;
                        end
                    end
                    // No timeout here: a core that never acknowledges stays parked in start.
                    CStart: begin
                        if (cores.core_start_done[n]) begin
                            cst_q[n]   <= CRun;
                            start_q[n] <= 1'b0;
                            run_q[n]   <= '0;
                        end
                    end
                    CRun: begin
                        if (cores.core_finish[n] || run_q[n] == RunLast) begin
                            cst_q[n]  <= CIdle;
                            hold_q[n] <= '0;
                            rst_q[n]  <= 1'b1;
                            if (!cores.core_finish[n]) begin
                                terr_q <= 1'b1;
                            end
                        end else begin
                            run_q[n] <= run_q[n] + 1'b1;
                        end
                    end
                    default: begin
                        cst_q[n]   <= CIdle;
                        hold_q[n]  <= '0;
                        rst_q[n]   <= 1'b1;
                        start_q[n] <= 1'b0;
                    end
                endcase
            end

            if (|disp_oh) begin
                next_key_q <= next_key_q + 25'd1;
            end

            // Global search FSM; its assignments come last so a find overrides the
            // per-core updates above.
            unique case (gst_q)
                GIdle, GDone: begin
                    if (go) begin
                        gst_q        <= GRun;
                        next_key_q   <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        found_q      <= 1'b0;
                        terr_q       <= 1'b0;
                        found_key_q  <= '0;
                        found_core_q <= '0;
                    end
                end
                GRun: begin
                    if (find_v) begin
                        gst_q        <= GDone;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        found_q      <= 1'b1;
                        found_key_q  <= find_key;
                        found_core_q <= find_idx;
                        for (int n = 0; n < int'(NUM_CORES); n++) begin
                            if (cst_q[n] != CIdle) begin
                                hold_q[n] <= '0;
                            end
                            cst_q[n]   <= CIdle;
                            rst_q[n]   <= 1'b1;
                            start_q[n] <= 1'b0;
                        end
                    end else if (!keys_left && all_idle) begin
                        gst_q  <= GDone;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    gst_q <= GIdle;
                end
            endcase
        end
    end

    assign cores.core_reset = rst_q;
    assign cores.core_start = start_q;
    assign cores.core_key   = key_flat;
    assign busy             = busy_q;
    assign done             = done_q;
    assign found            = found_q;
    assign found_key        = found_key_q;
    assign found_core       = found_core_q;
    assign timeout_err      = terr_q;
endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Bench for rc4_core_scheduler: NUM_CORES=4, KEY_MAX=7, RESET_CYCLES=2, RUN_TIMEOUT=50.
// A behavioural core array answers start after one cycle and finishes after a per-core
// run length; verdicts are chosen per test (matching key, forced mask, hang, stall).
module tb_rc4_core_scheduler;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        busy, done, found, timeout_err;
    logic [23:0] found_key;
    logic [2:0]  found_core;

    rc4_core_scheduler_if #(.NUM_CORES(NC)) bus ();

    rc4_core_scheduler #(
        .NUM_CORES   (NC),
        .KEY_MAX     (24'd7),
        .RESET_CYCLES(2),
        .RUN_TIMEOUT (50)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .go         (go),
        .cores      (bus),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .found_key  (found_key),
        .found_core (found_core),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Core model configuration
    logic          good_en;
    logic [23:0]   good_key;
    logic [NC-1:0] force_mask;
    int            hang_core;
    int            stall_core;
    logic [31:0]   cur_rl;

    logic [NC-1:0] sd_m, fin_m, kf_m;
    int            ph_m  [NC];
    int            cnt_m [NC];

    assign bus.core_start_done = sd_m;
    assign bus.core_finish     = fin_m;
    assign bus.core_keyfound   = kf_m;

    always @(posedge clk) begin
        for (int n = 0; n < NC; n++) begin
            if (bus.core_reset[n]) begin
                ph_m[n]  <= 0;
                sd_m[n]  <= 1'b0;
                fin_m[n] <= 1'b0;
                kf_m[n]  <= 1'b0;
            end else begin
                case (ph_m[n])
                    0: if (bus.core_start[n] && stall_core != n) begin
                        sd_m[n]  <= 1'b1;
                        ph_m[n]  <= 1;
                        cnt_m[n] <= int'(cur_rl[8*n +: 8]);
                    end
                    1: begin
                        sd_m[n] <= 1'b0;
                        if (cnt_m[n] != 0) begin
                            cnt_m[n] <= cnt_m[n] - 1;
                        end else if (hang_core != n) begin
                            fin_m[n] <= 1'b1;
                            kf_m[n]  <= (good_en && bus.core_key[24*n +: 24] == good_key) ||
                                        force_mask[n];
                            ph_m[n]  <= 2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Dispatch monitor: counts start rising edges and how often each key was handed out
    logic          clr_mon;
    logic [NC-1:0] prev_start;
    int            disp_cnt;
    int            key_seen [16];

    always @(posedge clk) begin
        if (clr_mon) begin
            disp_cnt <= 0;
            for (int k = 0; k < 16; k++) key_seen[k] <= 0;
        end else begin
            for (int n = 0; n < NC; n++) begin
                if (bus.core_start[n] && !prev_start[n]) begin : rec
                    logic [23:0] kk;
                    kk = bus.core_key[24*n +: 24];
                    disp_cnt <= disp_cnt + 1;
                    if (kk < 24'd16) key_seen[kk[3:0]] <= key_seen[kk[3:0]] + 1;
                end
            end
        end
        prev_start <= bus.core_start;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go      = 1'b1;
        clr_mon = 1'b1;
        @(negedge clk);
        go      = 1'b0;
        clr_mon = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (!done && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    function automatic logic keys_ok();
        logic ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (key_seen[k] != ((k < disp_cnt) ? 1 : 0)) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic set_cfg(input logic en, input logic [23:0] gk, input logic [NC-1:0] fm,
                           input int hc, input logic [31:0] rl);
        good_en    = en;
        good_key   = gk;
        force_mask = fm;
        hang_core  = hc;
        cur_rl     = rl;
    endtask

    typedef struct {
        logic          good_en;
        logic [23:0]   good_key;
        logic [NC-1:0] force_mask;
        int            hang_core;
        logic [31:0]   rl;
        logic          exp_found;
        logic [23:0]   exp_key;
        logic [2:0]    exp_core;
        logic          exp_terr;
        int            exp_disp;
    } vec_t;

    vec_t vecs [6];
    logic [3:0] exp_rst [6];

    initial begin
        // Table: cores dispatched on consecutive cycles and redispatched 10 cycles later,
        // so core k tests keys k and k+4.
        vecs[0] = '{1'b1, 24'd5, 4'b0000, -1, 32'h04040404, 1'b1, 24'd5, 3'd1, 1'b0, 8};
        vecs[1] = '{1'b0, 24'd0, 4'b0000, -1, 32'h04040404, 1'b0, 24'd0, 3'd0, 1'b0, 8};
        // Core 1 runs two cycles longer, so cores 1 and 3 report in the same cycle
        vecs[2] = '{1'b0, 24'd0, 4'b1010, -1, 32'h04040604, 1'b1, 24'd1, 3'd1, 1'b0, 4};
        vecs[3] = '{1'b0, 24'd0, 4'b0000,  2, 32'h04040404, 1'b0, 24'd0, 3'd0, 1'b1, 8};
        vecs[4] = '{1'b1, 24'd7, 4'b0000, -1, 32'h04040404, 1'b1, 24'd7, 3'd3, 1'b0, 8};
        vecs[5] = '{1'b1, 24'd0, 4'b0000, -1, 32'h04040404, 1'b1, 24'd0, 3'd0, 1'b0, 4};
        exp_rst = '{4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

        reset      = 1'b1;
        go         = 1'b0;
        clr_mon    = 1'b1;
        stall_core = -1;
        set_cfg(1'b1, 24'd5, '0, -1, 32'h04040404);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_core_reset", {28'd0, bus.core_reset}, 32'hF);
        check("rst_core_start", {28'd0, bus.core_start}, 32'h0);
        check("rst_core_key", {31'd0, |bus.core_key}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_found_key", {8'd0, found_key}, 32'd0);
        check("rst_found_core", {29'd0, found_core}, 32'd0);

        // Startup: go in the first cycle; core 0 waits for its hold counter to saturate
        reset   = 1'b0;
        go      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            go      = 1'b0;
            clr_mon = 1'b0;
            if (i == 0) check("start_busy", {31'd0, busy}, 32'd1);
            check($sformatf("start_rst_%0d", i), {28'd0, bus.core_reset}, {28'd0, exp_rst[i]});
            if (i == 2) check("start_core0_start", {31'd0, bus.core_start[0]}, 32'd1);
            if (i >= 2)
                check($sformatf("start_key_%0d", i - 2), {8'd0, bus.core_key[24*(i-2) +: 24]},
                      i - 2);
        end
        wait_done("start");
        check("start_found", {31'd0, found}, 32'd1);
        check("start_found_key", {8'd0, found_key}, 32'd5);
        check("start_found_core", {29'd0, found_core}, 32'd1);

        // Table-driven searches
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].good_en, vecs[v].good_key, vecs[v].force_mask, vecs[v].hang_core,
                    vecs[v].rl);
            repeat (3) @(negedge clk);
            pulse_go();
            check($sformatf("v%0d_busy_run", v), {31'd0, busy}, 32'd1);
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_found", v), {31'd0, found}, {31'd0, vecs[v].exp_found});
            check($sformatf("v%0d_found_key", v), {8'd0, found_key}, {8'd0, vecs[v].exp_key});
            check($sformatf("v%0d_found_core", v), {29'd0, found_core},
                  {29'd0, vecs[v].exp_core});
            check($sformatf("v%0d_terr", v), {31'd0, timeout_err}, {31'd0, vecs[v].exp_terr});
            check($sformatf("v%0d_core_reset", v), {28'd0, bus.core_reset}, 32'hF);
            check($sformatf("v%0d_core_start", v), {28'd0, bus.core_start}, 32'h0);
            check($sformatf("v%0d_dispatches", v), disp_cnt, vecs[v].exp_disp);
            check($sformatf("v%0d_keys_once", v), {31'd0, keys_ok()}, 32'd1);
        end

        // Reset mid-search, go while held in reset, then a clean rerun
        set_cfg(1'b1, 24'd5, '0, -1, 32'h04040404);
        repeat (3) @(negedge clk);
        pulse_go();
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_core_reset", {28'd0, bus.core_reset}, 32'hF);
        check("mid_core_start", {28'd0, bus.core_start}, 32'h0);
        check("mid_core_key", {31'd0, |bus.core_key}, 32'd0);
        pulse_go();
        check("mid_go_in_reset", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pulse_go();
        wait_done("rerun");
        check("rerun_found", {31'd0, found}, 32'd1);
        check("rerun_found_key", {8'd0, found_key}, 32'd5);
        check("rerun_found_core", {29'd0, found_core}, 32'd1);
        check("rerun_dispatches", disp_cnt, 8);
        check("rerun_keys_once", {31'd0, keys_ok()}, 32'd1);

        // Core 0 never acknowledges start: it must stay in start with no timeout
        set_cfg(1'b0, 24'd0, '0, -1, 32'h04040404);
        stall_core = 0;
        repeat (3) @(negedge clk);
        pulse_go();
        repeat (200) @(negedge clk);
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_done", {31'd0, done}, 32'd0);
        check("stall_core0_start", {31'd0, bus.core_start[0]}, 32'd1);
        check("stall_terr", {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        stall_core = -1;
        reset      = 1'b0;
        @(negedge clk);
        check("stall_reset_busy", {31'd0, busy}, 32'd0);
        check("stall_reset_core_reset", {28'd0, bus.core_reset}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
